// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory access controller: sequencer state encodings and defaults.
package mem_access_ctrl_pkg;

    localparam int WORD_SIZE_DEF      = 16;
    localparam int TIMEOUT_CYCLES_DEF = 64;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_I    = 3'd1,
        RD_D    = 3'd2,
        WR_D    = 3'd3,
        RECOVER = 3'd4
    } state_e;

    // States in which a strobe is on the bus and the wait timer runs.
    function automatic logic isAccess(state_e s);
        return (s == RD_I) || (s == RD_D) || (s == WR_D);
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Requester and memory handshake signals of the shared-bus controller.
interface mem_access_ctrl_if
    import mem_access_ctrl_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF
);
    logic                 if_req;
    logic [WORD_SIZE-1:0] if_addr;
    logic [WORD_SIZE-1:0] if_rdata;
    logic                 if_done;
    logic                 d_req;
    logic                 d_we;
    logic [WORD_SIZE-1:0] d_addr;
    logic [WORD_SIZE-1:0] d_wdata;
    logic [WORD_SIZE-1:0] d_rdata;
    logic                 d_done;
    logic                 err;
    logic                 busy;
    logic                 readM;
    logic                 writeM;
    logic [WORD_SIZE-1:0] address;
    logic                 inputReady;
    logic                 ackOutput;

    // The controller owns the memory bus, so it is the master side.
    modport master (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, inputReady, ackOutput,
        output if_rdata, if_done, d_rdata, d_done, err, busy, readM, writeM, address
    );

    modport slave (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, inputReady, ackOutput,
        input  if_rdata, if_done, d_rdata, d_done, err, busy, readM, writeM, address
    );

endinterface

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter for one memory access: cleared outside accesses, saturates and flags expiry.
module mem_wait_timer
    import mem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear_i,
    output logic expired_o
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (count_q != LAST) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == LAST);

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-owner sequencer for the shared memory bus; data port has fixed priority over fetch.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int WORD_SIZE      = WORD_SIZE_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    mem_access_ctrl_if.master    bus,
    inout  wire  [WORD_SIZE-1:0] data
);
    state_e               state_q;
    logic                 readM_q;
    logic                 writeM_q;
    logic [WORD_SIZE-1:0] address_q;
    logic [WORD_SIZE-1:0] wdata_q;
    logic [WORD_SIZE-1:0] if_rdata_q;
    logic [WORD_SIZE-1:0] d_rdata_q;
    logic                 if_done_q;
    logic                 d_done_q;
    logic                 err_q;
    logic                 timerExpired;

    mem_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear_i  (!isAccess(state_q)),
        .expired_o(timerExpired)
    );

    // Done/err default low so they stay high only for the RECOVER cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            readM_q    <= 1'b0;
            writeM_q   <= 1'b0;
            address_q  <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            if_done_q  <= 1'b0;
            d_done_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if_done_q <= 1'b0;
            d_done_q  <= 1'b0;
            err_q     <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.d_req) begin
                        address_q <= bus.d_addr;
                        if (bus.d_we) begin
                            wdata_q  <= bus.d_wdata;
                            writeM_q <= 1'b1;
                            state_q  <= WR_D;
                        end else begin
                            readM_q <= 1'b1;
                            state_q <= RD_D;
                        end
                    end else if (bus.if_req) begin
                        address_q <= bus.if_addr;
                        readM_q   <= 1'b1;
                        state_q   <= RD_I;
                    end
                end
                RD_I, RD_D: begin
                    // A handshake on the expiry edge still counts as success.
                    if (bus.inputReady || timerExpired) begin
                        readM_q <= 1'b0;
                        err_q   <= !bus.inputReady;
                        state_q <= RECOVER;
                        if (state_q == RD_I) begin
                            if_done_q <= 1'b1;
                            if (bus.inputReady) if_rdata_q <= data;
                        end else begin
                            d_done_q <= 1'b1;
                            if (bus.inputReady) d_rdata_q <= data;
                        end
                    end
                end
                WR_D: begin
                    if (bus.ackOutput || timerExpired) begin
                        writeM_q <= 1'b0;
                        d_done_q <= 1'b1;
                        err_q    <= !bus.ackOutput;
                        state_q  <= RECOVER;
                    end
                end
                RECOVER: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data         = writeM_q ? wdata_q : 'z;
    assign bus.readM    = readM_q;
    assign bus.writeM   = writeM_q;
    assign bus.address  = address_q;
    assign bus.if_rdata = if_rdata_q;
    assign bus.d_rdata  = d_rdata_q;
    assign bus.if_done  = if_done_q;
    assign bus.d_done   = d_done_q;
    assign bus.err      = err_q;
    assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed, table-driven bench for mem_access_ctrl with a hand-driven memory model.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        memDrive = 1'b0;
    logic [15:0] memData = 16'h0000;
    wire  [15:0] data;
    int          checkCount = 0;
    int          passCount = 0;

    mem_access_ctrl_if #(.WORD_SIZE(16)) bus ();

    mem_access_ctrl #(
        .WORD_SIZE(16),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus),
        .data   (data)
    );

    assign data = memDrive ? memData : 'z;

    always #5 clk = ~clk;

    typedef struct {
        logic        ifReq;
        logic        dReq;
        logic        dWe;
        logic [15:0] ifAddr;
        logic [15:0] dAddr;
        logic [15:0] dWdata;
        logic        expReadM;
        logic        expWriteM;
        logic        expBusy;
        logic [15:0] expAddr;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checkCount++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            passCount++;
        end
    endtask

    task automatic clearInputs();
        bus.if_req     = 1'b0;
        bus.if_addr    = 16'h0000;
        bus.d_req      = 1'b0;
        bus.d_we       = 1'b0;
        bus.d_addr     = 16'h0000;
        bus.d_wdata    = 16'h0000;
        bus.inputReady = 1'b0;
        bus.ackOutput  = 1'b0;
        memDrive       = 1'b0;
    endtask

    task automatic doReset();
        clearInputs();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.if_req  = v.ifReq;
        bus.if_addr = v.ifAddr;
        bus.d_req   = v.dReq;
        bus.d_we    = v.dWe;
        bus.d_addr  = v.dAddr;
        bus.d_wdata = v.dWdata;
    endtask

    // Zero-wait read through either port; checks strobe, done, data and return to IDLE.
    task automatic doRead(input logic isData, input logic [15:0] addr, input logic [15:0] val,
                          input string tag);
        if (isData) begin
            bus.d_req  = 1'b1;
            bus.d_we   = 1'b0;
            bus.d_addr = addr;
        end else begin
            bus.if_req  = 1'b1;
            bus.if_addr = addr;
        end
        memDrive = 1'b1;
        memData  = val;
        tick();
        checkOutput({tag, " readM"}, 16'(bus.readM), 16'd1);
        checkOutput({tag, " address"}, bus.address, addr);
        bus.inputReady = 1'b1;
        tick();
        checkOutput({tag, " readM low"}, 16'(bus.readM), 16'd0);
        checkOutput({tag, " done"}, 16'(isData ? bus.d_done : bus.if_done), 16'd1);
        checkOutput({tag, " rdata"}, isData ? bus.d_rdata : bus.if_rdata, val);
        checkOutput({tag, " err"}, 16'(bus.err), 16'd0);
        bus.inputReady = 1'b0;
        bus.d_req      = 1'b0;
        bus.if_req     = 1'b0;
        tick();
        checkOutput({tag, " busy after"}, 16'(bus.busy), 16'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1);
    end

    initial begin
        int cnt;
        int bothHigh;
        int nStrobe;
        int dDoneCycle;
        int ifDoneCycle;
        logic prevReadM;
        logic [15:0] strobeAddr [2];

        // ifReq dReq dWe ifAddr dAddr dWdata | readM writeM busy address
        vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0010};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0020, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0020};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h0030, 16'hBEEF, 1'b0, 1'b1, 1'b1, 16'h0030};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 16'h0011, 16'h0044, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0044};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 16'h0012, 16'h0055, 16'h1357, 1'b0, 1'b1, 1'b1, 16'h0055};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 16'h0013, 16'h0066, 16'h2468, 1'b0, 1'b0, 1'b0, 16'h0000};

        $display("[TB] reset state");
        doReset();
        checkOutput("reset readM", 16'(bus.readM), 16'd0);
        checkOutput("reset writeM", 16'(bus.writeM), 16'd0);
        checkOutput("reset address", bus.address, 16'h0000);
        checkOutput("reset busy", 16'(bus.busy), 16'd0);
        checkOutput("reset done/err", {13'd0, bus.if_done, bus.d_done, bus.err}, 16'd0);
        checkOutput("reset if_rdata", bus.if_rdata, 16'h0000);
        checkOutput("reset d_rdata", bus.d_rdata, 16'h0000);

        $display("[TB] arbitration vectors");
        for (int i = 0; i < 6; i++) begin
            doReset();
            applyStimulus(vecs[i]);
            tick();
            checkOutput($sformatf("vec%0d readM", i), 16'(bus.readM), 16'(vecs[i].expReadM));
            checkOutput($sformatf("vec%0d writeM", i), 16'(bus.writeM), 16'(vecs[i].expWriteM));
            checkOutput($sformatf("vec%0d busy", i), 16'(bus.busy), 16'(vecs[i].expBusy));
            checkOutput($sformatf("vec%0d address", i), bus.address, vecs[i].expAddr);
            if (vecs[i].expWriteM) begin
                checkOutput($sformatf("vec%0d data", i), data, vecs[i].dWdata);
            end
        end

        $display("[TB] fetch with two wait cycles");
        doReset();
        bus.if_req  = 1'b1;
        bus.if_addr = 16'h0010;
        memDrive    = 1'b1;
        memData     = 16'h6A01;
        tick();
        checkOutput("fetch readM c1", 16'(bus.readM), 16'd1);
        checkOutput("fetch address", bus.address, 16'h0010);
        tick();
        checkOutput("fetch readM c2", 16'(bus.readM), 16'd1);
        tick();
        checkOutput("fetch readM c3", 16'(bus.readM), 16'd1);
        checkOutput("fetch no early done", 16'(bus.if_done), 16'd0);
        bus.inputReady = 1'b1;
        tick();
        checkOutput("fetch readM recover", 16'(bus.readM), 16'd0);
        checkOutput("fetch if_done", 16'(bus.if_done), 16'd1);
        checkOutput("fetch if_rdata", bus.if_rdata, 16'h6A01);
        checkOutput("fetch busy recover", 16'(bus.busy), 16'd1);
        bus.inputReady = 1'b0;
        bus.if_req     = 1'b0;
        tick();
        checkOutput("fetch done cleared", 16'(bus.if_done), 16'd0);
        checkOutput("fetch rdata held", bus.if_rdata, 16'h6A01);
        checkOutput("fetch idle", 16'(bus.busy), 16'd0);

        $display("[TB] load/fetch collision");
        doReset();
        bus.if_req  = 1'b1;
        bus.if_addr = 16'h0100;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 16'h0020;
        memDrive    = 1'b1;
        bothHigh    = 0;
        nStrobe     = 0;
        dDoneCycle  = -1;
        ifDoneCycle = -1;
        prevReadM   = 1'b0;
        strobeAddr[0] = 16'h0000;
        strobeAddr[1] = 16'h0000;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (bus.readM && bus.writeM) bothHigh++;
            if (bus.readM && !prevReadM && nStrobe < 2) begin
                strobeAddr[nStrobe] = bus.address;
                nStrobe++;
            end
            prevReadM = bus.readM;
            if (bus.d_done) begin
                dDoneCycle = i;
                bus.d_req  = 1'b0;
            end
            if (bus.if_done) begin
                ifDoneCycle = i;
                bus.if_req  = 1'b0;
            end
            bus.inputReady = bus.readM;
            memData = (bus.address == 16'h0020) ? 16'hD0D0 : 16'h1F1F;
        end
        checkOutput("collision strobes", 16'(nStrobe), 16'd2);
        checkOutput("collision first addr", strobeAddr[0], 16'h0020);
        checkOutput("collision second addr", strobeAddr[1], 16'h0100);
        checkOutput("collision d_done cycle", 16'(dDoneCycle), 16'd2);
        checkOutput("collision if_done cycle", 16'(ifDoneCycle), 16'd5);
        checkOutput("collision both strobes", 16'(bothHigh), 16'd0);
        checkOutput("collision d_rdata", bus.d_rdata, 16'hD0D0);
        checkOutput("collision if_rdata", bus.if_rdata, 16'h1F1F);

        $display("[TB] store with one wait cycle");
        doReset();
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 16'h0030;
        bus.d_wdata = 16'hBEEF;
        tick();
        checkOutput("store writeM", 16'(bus.writeM), 16'd1);
        checkOutput("store readM", 16'(bus.readM), 16'd0);
        checkOutput("store address", bus.address, 16'h0030);
        checkOutput("store data", data, 16'hBEEF);
        bus.inputReady = 1'b1;
        tick();
        checkOutput("store ignores inputReady", 16'(bus.writeM), 16'd1);
        checkOutput("store no early done", 16'(bus.d_done), 16'd0);
        checkOutput("store data held", data, 16'hBEEF);
        bus.inputReady = 1'b0;
        bus.ackOutput  = 1'b1;
        tick();
        checkOutput("store writeM low", 16'(bus.writeM), 16'd0);
        checkOutput("store d_done", 16'(bus.d_done), 16'd1);
        checkOutput("store err", 16'(bus.err), 16'd0);
        bus.ackOutput = 1'b0;
        bus.d_req     = 1'b0;
        memDrive      = 1'b1;
        memData       = 16'h1234;
        #1;
        checkOutput("store bus released", data, 16'h1234);
        memDrive = 1'b0;
        tick();
        checkOutput("store done cleared", 16'(bus.d_done), 16'd0);
        checkOutput("store idle", 16'(bus.busy), 16'd0);

        $display("[TB] read timeout");
        doReset();
        doRead(1'b0, 16'h0040, 16'h5555, "prefetch");
        bus.if_req     = 1'b1;
        bus.if_addr    = 16'h0044;
        bus.ackOutput  = 1'b1;
        memDrive       = 1'b1;
        memData        = 16'hAAAA;
        tick();
        cnt = 0;
        while (bus.readM && cnt < 200) begin
            cnt++;
            tick();
        end
        checkOutput("timeout readM cycles", 16'(cnt), 16'd64);
        checkOutput("timeout if_done", 16'(bus.if_done), 16'd1);
        checkOutput("timeout err", 16'(bus.err), 16'd1);
        checkOutput("timeout rdata unchanged", bus.if_rdata, 16'h5555);
        bus.if_req    = 1'b0;
        bus.ackOutput = 1'b0;
        tick();
        checkOutput("timeout err cleared", 16'(bus.err), 16'd0);
        checkOutput("timeout idle", 16'(bus.busy), 16'd0);

        $display("[TB] handshake on the expiry edge");
        bus.if_req  = 1'b1;
        bus.if_addr = 16'h0048;
        memData     = 16'h9999;
        tick();
        cnt = 0;
        while (bus.readM && cnt < 200) begin
            cnt++;
            if (cnt == 64) bus.inputReady = 1'b1;
            tick();
        end
        checkOutput("late handshake cycles", 16'(cnt), 16'd64);
        checkOutput("late handshake if_done", 16'(bus.if_done), 16'd1);
        checkOutput("late handshake err", 16'(bus.err), 16'd0);
        checkOutput("late handshake rdata", bus.if_rdata, 16'h9999);
        bus.inputReady = 1'b0;
        bus.if_req     = 1'b0;
        tick();

        $display("[TB] reset during store");
        doReset();
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 16'h0060;
        bus.d_wdata = 16'hCAFE;
        tick();
        checkOutput("midreset writeM before", 16'(bus.writeM), 16'd1);
        bus.d_req = 1'b0;
        reset_n   = 1'b0;
        tick();
        reset_n = 1'b1;
        checkOutput("midreset writeM", 16'(bus.writeM), 16'd0);
        checkOutput("midreset busy", 16'(bus.busy), 16'd0);
        checkOutput("midreset d_done", 16'(bus.d_done), 16'd0);
        checkOutput("midreset address", bus.address, 16'h0000);
        tick();
        checkOutput("midreset no late done", 16'(bus.d_done), 16'd0);
        doRead(1'b1, 16'h0070, 16'h4321, "postreset load");

        $display("[TB] back-to-back fetches");
        doReset();
        bus.if_req  = 1'b1;
        bus.if_addr = 16'h0080;
        memDrive    = 1'b1;
        memData     = 16'h7777;
        for (int i = 1; i <= 12; i++) begin
            tick();
            checkOutput($sformatf("b2b readM c%0d", i), 16'(bus.readM), 16'((i % 3) == 1));
            checkOutput($sformatf("b2b if_done c%0d", i), 16'(bus.if_done), 16'((i % 3) == 2));
            bus.inputReady = bus.readM;
        end
        checkOutput("b2b if_rdata", bus.if_rdata, 16'h7777);
        clearInputs();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
